feature_extractor: RTL and testbench
====================================

Name: feature_extractor

Overview:
Upstream feature stage for the perceptron datapath. It watches the VGA pixel stream (colour plus Draw_X/Draw_Y) and reduces a fixed on-screen window to a GRID_W x GRID_H binary feature vector. Each feature is one cell: 1 if the cell is mostly dark, else 0. Features are emitted serially, one bit per strobe, to the weighted-sum and delta-weight blocks, with a per-frame sum-reset pulse and an end-of-vector pulse.

Parameters:
X0, 192, left column of the capture window
Y0, 112, top row of the capture window
CELL, 16, cell edge in pixels; power of two, range 2..32
GRID_W, 16, cells per row
GRID_H, 16, cell rows

Ports:
Clk  in  1  pixel clock (VGA controller clock); one Draw_X/Draw_Y coordinate per cycle
RST  in  1  asynchronous reset, active-high
Red  in  10  pixel red, valid with Draw_X/Draw_Y
Green  in  10  pixel green
Blue  in  10  pixel blue
Draw_X  in  10  current pixel column
Draw_Y  in  10  current pixel row
Thresh  in  10  darkness threshold
Enable  in  1  process next frame; sampled only at frame start
x_values  out  1  feature bit, valid when Get=1
Get  out  1  one-cycle feature strobe
Index  out  log2(GRID_W*GRID_H)  row-major feature index, valid when Get=1
RstH  out  1  one-cycle pulse at start of an accepted frame
Get_done  out  1  one-cycle pulse after the last feature
Busy  out  1  high from an accepted frame start until Get_done

Behaviour:
- Reset: RST is asynchronous and active-high. All outputs go to 0, the state goes to IDLE, all accumulators clear. Reset mid-frame abandons that frame; no Get is issued until the next accepted frame start.
- Input stage: Red, Green, Blue, Draw_X, Draw_Y register once (stage 1).
- Gray value: gray = (R + 2G + B) >> 2, computed at 12-bit width, then truncated to 10 bits.
- Dark pixel: dark = (gray < Thresh), unsigned compare.
- Frame start: the stage-1 coordinate is (0,0) and the previous stage-1 coordinate was not (0,0). A held (0,0) does not retrigger.
- State machine:
  - IDLE: on frame start with Enable=1, go to ACTIVE, pulse RstH on the next cycle, set Busy, and clear the accumulators. With Enable=0, stay in IDLE.
  - ACTIVE: accumulate and emit features. After the last feature is emitted, go to DONE.
  - DONE: pulse Get_done for one cycle, clear Busy, and return to IDLE.
  - A frame start seen while in ACTIVE (the frame was truncated) behaves as reset-then-IDLE. A new frame starts only if Enable=1; the truncated frame never produces Get_done.
- In-window pixel: X0 <= X < X0+CELL*GRID_W and Y0 <= Y < Y0+CELL*GRID_H.
  - cx = (X-X0)/CELL; cy = (Y-Y0)/CELL.
  - Pixels outside the window are ignored.
- Accumulators: GRID_W counters, one per cell column, each log2(CELL*CELL)+1 bits wide. No saturation is needed because the maximum is CELL*CELL.
  - An in-window dark pixel increments counter[cx].
- Cell completion: the pixel at local column CELL-1 of the cell, on local row CELL-1 of the cell band.
  - Form total = counter[cx] + dark_of_this_pixel.
  - Feature = (total >= CELL*CELL/2). A tie gives 1.
  - Clear counter[cx] in the same cycle, ready for the next cell band.
- Output latency: Get asserts exactly 2 Clk cycles after the completing pixel is presented on the input ports. x_values and Index are registered alongside Get.
- Output order: row-major, Index = cy*GRID_W + cx; the first emitted Index is 0.
  - Get is never asserted on two consecutive cycles, since cells are >= 2 pixels apart.
- End of vector: Get_done asserts the cycle after the Get with Index = GRID_W*GRID_H-1.
- Enable changes mid-frame have no effect.
- Blanking: coordinates >= 640 or >= 480 fall outside the window and are ignored.

Test Plan:
- All pixels R=G=B=0, Thresh=512, Enable=1, one full 800x525 frame -> RstH once; 256 Gets with x_values=1 and Index 0..255 in order; Get_done the cycle after Index 255; Busy then falls.
- All pixels R=G=B=1023, Thresh=512 -> 256 Gets, all x_values=0. Check the first Get lands 2 cycles after (X0+15, Y0+15) is presented.
- Cell (0,0) with exactly 128 dark pixels -> Index 0 gives x_values=1. Same cell with 127 dark -> x_values=0. Neighbouring cells are all bright and give 0.
- Enable=0 at frame start, toggled to 1 mid-frame -> no RstH, Get or Get_done that frame; the next frame is processed normally.
- RST pulsed after Index 100 is emitted -> all outputs 0 immediately. No Get until the next frame start; the next frame emits Index 0..255 with correct values (no carried-over counts).
- Checkerboard of dark/bright cells -> x_values = (cx+cy) even, for all 256 features.

Source files
------------

// File: rtl/feature_extractor.sv
// feature_extractor: reduces a fixed window of the VGA pixel stream to a
// GRID_W x GRID_H binary feature vector (1 = mostly dark cell) and streams
// it out one bit per Get strobe in row-major order.
module feature_extractor #(
  parameter int unsigned X0     = 192,
  parameter int unsigned Y0     = 112,
  parameter int unsigned CELL   = 16,
  parameter int unsigned GRID_W = 16,
  parameter int unsigned GRID_H = 16,
  localparam int unsigned IDX_W = $clog2(GRID_W * GRID_H)
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic [9:0]       Red,
  input  logic [9:0]       Green,
  input  logic [9:0]       Blue,
  input  logic [9:0]       Draw_X,
  input  logic [9:0]       Draw_Y,
  input  logic [9:0]       Thresh,
  input  logic             Enable,
  output logic             x_values,
  output logic             Get,
  output logic [IDX_W-1:0] Index,
  output logic             RstH,
  output logic             Get_done,
  output logic             Busy
);

  localparam int unsigned LOG_CELL = $clog2(CELL);
  localparam int unsigned CX_W     = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int unsigned CY_W     = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int unsigned CNT_W    = $clog2(CELL * CELL) + 1;
  localparam int unsigned WIN_W    = CELL * GRID_W;
  localparam int unsigned WIN_H    = CELL * GRID_H;
  localparam int unsigned HALF     = (CELL * CELL) / 2;
  localparam int unsigned LAST_IDX = GRID_W * GRID_H - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_e;

  // Stage 1: registered pixel and coordinate
  logic [9:0] red_q, green_q, blue_q, x_q, y_q;
  logic       prev_zero_q;
  logic       at_origin;

  // FSM and output registers
  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             rsth_q, rsth_d;
  logic             done_q, done_d;
  logic             get_q, get_d;
  logic             xval_q, xval_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Per-column dark-pixel counters for the current cell band
  logic [CNT_W-1:0] cnt_q [GRID_W];
  logic [CNT_W-1:0] cnt_d [GRID_W];

  // Pixel classification
  logic [11:0]      gray_sum;
  logic [9:0]       gray;
  logic             dark;
  logic [10:0]      rel_x, rel_y;
  logic             in_win;
  logic [CX_W-1:0]  cx;
  logic [CY_W-1:0]  cy;
  logic [LOG_CELL-1:0] lx, ly;
  logic             cell_end;
  logic [IDX_W-1:0] cell_idx;
  logic             is_last;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] total;
  logic             feature;

  // Frame control
  logic frame_start;
  logic accept;
  logic clear_acc;
  logic process;

  // Capture the incoming pixel and remember whether the last one was (0,0)
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      // Reset parks the coordinate at (0,0); treat it as held so it cannot
      // fake a frame start.
      prev_zero_q <= 1'b1;
    end else begin
      red_q       <= Red;
      green_q     <= Green;
      blue_q      <= Blue;
      x_q         <= Draw_X;
      y_q         <= Draw_Y;
      prev_zero_q <= at_origin;
    end
  end

  assign at_origin   = (x_q == 10'd0) && (y_q == 10'd0);
  assign frame_start = at_origin && !prev_zero_q;

  // Luma-like gray value with green weighted twice, then darkness test
  assign gray_sum = {2'b00, red_q} + {1'b0, green_q, 1'b0} + {2'b00, blue_q};
  assign gray     = 10'(gray_sum >> 2);
  assign dark     = (gray < Thresh);

  // Window membership and cell coordinates; blanking is excluded explicitly
  assign rel_x  = {1'b0, x_q} - 11'(X0);
  assign rel_y  = {1'b0, y_q} - 11'(Y0);
  assign in_win = (x_q >= 10'(X0)) && (rel_x < 11'(WIN_W)) &&
                  (y_q >= 10'(Y0)) && (rel_y < 11'(WIN_H)) &&
                  (x_q < 10'd640) && (y_q < 10'd480);
  assign cx       = rel_x[LOG_CELL +: CX_W];
  assign cy       = rel_y[LOG_CELL +: CY_W];
  assign lx       = rel_x[LOG_CELL-1:0];
  assign ly       = rel_y[LOG_CELL-1:0];
  assign cell_end = in_win && (&lx) && (&ly);
  assign cell_idx = IDX_W'(cy) * IDX_W'(GRID_W) + IDX_W'(cx);
  assign is_last  = (cell_idx == IDX_W'(LAST_IDX));

  // Any frame start wipes the counters; pixels count only in an accepted frame
  assign accept    = frame_start && Enable;
  assign clear_acc = frame_start;
  assign process   = accept || ((state_q == S_ACTIVE) && !frame_start);

  // The completing pixel's own darkness is folded into the cell total
  assign cnt_cur = clear_acc ? '0 : cnt_q[cx];
  assign total   = cnt_cur + CNT_W'(dark);
  assign feature = (total >= CNT_W'(HALF));

  // Next state and registered outputs
  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    rsth_d  = 1'b0;
    done_d  = 1'b0;
    get_d   = 1'b0;
    xval_d  = 1'b0;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ACTIVE;
          rsth_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_ACTIVE: begin
        // A new frame start truncates the current frame; restart only if enabled
        if (frame_start) begin
          if (accept) begin
            rsth_d = 1'b1;
            busy_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_ACTIVE;
          rsth_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (process && cell_end) begin
      get_d  = 1'b1;
      xval_d = feature;
      idx_d  = cell_idx;
      if (is_last) begin
        state_d = S_DONE;
      end
    end
  end

  // Counter updates: accumulate dark pixels, clear the column on cell completion
  always_comb begin
    for (int i = 0; i < int'(GRID_W); i++) begin
      cnt_d[i] = clear_acc ? '0 : cnt_q[i];
    end
    if (process && in_win) begin
      cnt_d[cx] = cell_end ? '0 : total;
    end
  end

  // State, output and counter registers
  // NOTE: the counter array is plain flops, not a RAM, so it is reset like
  // any other state; a real memory would not be.
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      rsth_q  <= 1'b0;
      done_q  <= 1'b0;
      get_q   <= 1'b0;
      xval_q  <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < int'(GRID_W); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      rsth_q  <= rsth_d;
      done_q  <= done_d;
      get_q   <= get_d;
      xval_q  <= xval_d;
      idx_q   <= idx_d;
      for (int i = 0; i < int'(GRID_W); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign x_values = xval_q;
  assign Get      = get_q;
  assign Index    = idx_q;
  assign RstH     = rsth_q;
  assign Get_done = done_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_feature_extractor.sv
// Directed bench for feature_extractor. Uses 4-pixel cells so each frame
// (window plus a one-pixel border and a blanking pixel per row) stays short.
module tb_feature_extractor;

  localparam int X0    = 192;
  localparam int Y0    = 112;
  localparam int CELL  = 4;
  localparam int GW    = 16;
  localparam int GH    = 16;
  localparam int NCELL = GW * GH;

  logic       Clk = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] Red = '0, Green = '0, Blue = '0;
  logic [9:0] Draw_X = '0, Draw_Y = '0;
  logic [9:0] Thresh = 10'd512;
  logic       Enable = 1'b0;
  logic       x_values, Get, RstH, Get_done, Busy;
  logic [7:0] Index;

  always #5 Clk = ~Clk;

  feature_extractor #(
    .X0(X0), .Y0(Y0), .CELL(CELL), .GRID_W(GW), .GRID_H(GH)
  ) dut (
    .Clk(Clk), .RST(RST),
    .Red(Red), .Green(Green), .Blue(Blue),
    .Draw_X(Draw_X), .Draw_Y(Draw_Y),
    .Thresh(Thresh), .Enable(Enable),
    .x_values(x_values), .Get(Get), .Index(Index),
    .RstH(RstH), .Get_done(Get_done), .Busy(Busy)
  );

  typedef struct {
    int   cyc;
    int   idx;
    logic val;
  } ev_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  ev_t  exp_q[$];
  int   cur_mode;
  int   n_dark;
  bit   extra_dark;
  bit   expect_active;
  int   abort_idx;
  int   get_cnt, rsth_cnt, rsth_cyc, done_cnt, done_cyc;
  int   last_get_cyc, first_get_cyc, first_cmp_cyc, zero_cyc;
  logic busy_mid;

  function automatic bit in_win(int x, int y);
    return (x >= X0) && (x < X0 + GW*CELL) && (y >= Y0) && (y < Y0 + GH*CELL);
  endfunction

  // Pixel colour {R,G,B} for the current scenario; outside the window is dark
  function automatic logic [29:0] pix_color(int x, int y);
    int lx, ly, cx, cy;
    logic [29:0] drk, brt;
    drk = 30'd0;
    brt = {10'd1023, 10'd1023, 10'd1023};
    if (!in_win(x, y)) return drk;
    lx = (x - X0) % CELL;
    ly = (y - Y0) % CELL;
    cx = (x - X0) / CELL;
    cy = (y - Y0) / CELL;
    case (cur_mode)
      0: return drk;
      1: return brt;
      2: begin
        if (cx == 0 && cy == 0 &&
            ((ly*CELL + lx < n_dark) || (extra_dark && lx == CELL-1 && ly == CELL-1)))
          return drk;
        return brt;
      end
      3: return (((cx + cy) % 2) == 0) ? drk : brt;
      default: return {10'd100, 10'd200, 10'd300};
    endcase
  endfunction

  // Hand-derived expected feature for each scenario
  function automatic logic exp_bit(int idx);
    int cx, cy;
    cx = idx % GW;
    cy = idx / GW;
    case (cur_mode)
      0: return 1'b1;
      1: return 1'b0;
      2: return (idx == 0) ? ((n_dark + int'(extra_dark)) >= CELL*CELL/2) : 1'b0;
      3: return (((cx + cy) % 2) == 0);
      default: return (200 < int'(Thresh));  // gray of (100,200,300) is 200
    endcase
  endfunction

  // One pixel clock: drive a pixel, then check the outputs of this cycle
  task automatic step(input int x, input int y);
    ev_t e;
    @(posedge Clk);
    cyc++;
    #1;
    {Red, Green, Blue} = pix_color(x, y);
    Draw_X = 10'(x);
    Draw_Y = 10'(y);
    if (expect_active && in_win(x, y) &&
        ((x - X0) % CELL == CELL-1) && ((y - Y0) % CELL == CELL-1)) begin
      e.cyc = cyc + 2;
      e.idx = ((y - Y0) / CELL) * GW + (x - X0) / CELL;
      e.val = exp_bit(e.idx);
      exp_q.push_back(e);
      if (e.idx == 0) first_cmp_cyc = cyc;
    end
    @(negedge Clk);
    if (RstH === 1'b1) begin rsth_cnt++; rsth_cyc = cyc; end
    if (Get_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (Get === 1'b1) begin
      get_cnt++;
      last_get_cyc = cyc;
      if (first_get_cyc < 0) first_get_cyc = cyc;
    end
    total++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      if (Get !== 1'b1 || Index !== 8'(e.idx) || x_values !== e.val) begin
        bad++;
        $display("FAIL feature cyc=%0d: got Get=%b Index=%0d x=%b, want Get=1 Index=%0d x=%b",
                 cyc, Get, Index, x_values, e.idx, e.val);
      end
    end else if (Get !== 1'b0) begin
      bad++;
      $display("FAIL stray_get cyc=%0d: got Get=%b Index=%0d, want Get=0", cyc, Get, Index);
    end
    if (Get === 1'b1 && abort_idx >= 0 && int'(Index) == abort_idx) begin
      RST = 1'b1;
      #1;
      total++;
      if ({x_values, Get, Index, RstH, Get_done, Busy} !== 13'd0) begin
        bad++;
        $display("FAIL reset_outputs: got x=%b Get=%b Index=%0d RstH=%b done=%b Busy=%b, want all 0",
                 x_values, Get, Index, RstH, Get_done, Busy);
      end
      #1 RST = 1'b0;
      exp_q.delete();
      expect_active = 1'b0;
    end
  endtask

  // One frame: frame start, window rows with a border and a blanking pixel,
  // Enable flipped halfway down, then a short flush
  task automatic run_frame(input int mode, input logic en0, input int abort_i,
                           input logic [9:0] thr);
    cur_mode      = mode;
    Thresh        = thr;
    expect_active = en0;
    abort_idx     = abort_i;
    get_cnt = 0; rsth_cnt = 0; done_cnt = 0;
    rsth_cyc = -1; done_cyc = -1; last_get_cyc = -1;
    first_get_cyc = -1; first_cmp_cyc = -1;
    exp_q.delete();
    Enable = en0;
    step(639, 524);
    step(0, 0);
    zero_cyc = cyc;
    for (int y = Y0 - 1; y <= Y0 + GH*CELL; y++) begin
      if (y == Y0 + 32) begin
        Enable   = ~en0;
        busy_mid = Busy;
      end
      for (int x = X0 - 1; x <= X0 + GW*CELL; x++) step(x, y);
      step(700, y);
    end
    repeat (4) step(10, 479);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    total++;
    if (Get !== 1'b0 || x_values !== 1'b0 || Index !== 8'd0) begin
      bad++;
      $display("FAIL reset_data: got Get=%b x=%b Index=%0d, want 0 0 0", Get, x_values, Index);
    end
    total++;
    if (RstH !== 1'b0 || Get_done !== 1'b0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got RstH=%b done=%b Busy=%b, want 0 0 0", RstH, Get_done, Busy);
    end
    RST = 1'b0;
    @(negedge Clk);
    total++;
    if (Busy !== 1'b0 || Get !== 1'b0 || RstH !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got Busy=%b Get=%b RstH=%b, want 0 0 0", Busy, Get, RstH);
    end
  endtask

  task automatic test_dark();
    run_frame(0, 1'b1, -1, 10'd512);
    total++;
    if (rsth_cnt != 1 || rsth_cyc != zero_cyc + 2) begin
      bad++;
      $display("FAIL dark_rsth: got count=%0d cyc=%0d, want 1 at %0d", rsth_cnt, rsth_cyc, zero_cyc + 2);
    end
    total++;
    if (get_cnt != NCELL) begin
      bad++;
      $display("FAIL dark_gets: got %0d, want %0d", get_cnt, NCELL);
    end
    total++;
    if (done_cnt != 1 || done_cyc != last_get_cyc + 1) begin
      bad++;
      $display("FAIL dark_done: got count=%0d cyc=%0d, want 1 at %0d", done_cnt, done_cyc, last_get_cyc + 1);
    end
    total++;
    if (busy_mid !== 1'b1 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL dark_busy: got mid=%b end=%b, want 1 0", busy_mid, Busy);
    end
  endtask

  task automatic test_bright();
    run_frame(1, 1'b1, -1, 10'd512);
    total++;
    if (get_cnt != NCELL || done_cnt != 1) begin
      bad++;
      $display("FAIL bright_counts: got gets=%0d done=%0d, want %0d 1", get_cnt, done_cnt, NCELL);
    end
    total++;
    if (first_get_cyc != first_cmp_cyc + 2) begin
      bad++;
      $display("FAIL bright_latency: got first Get cyc=%0d, want %0d", first_get_cyc, first_cmp_cyc + 2);
    end
  endtask

  task automatic test_enable_off();
    run_frame(0, 1'b0, -1, 10'd512);
    total++;
    if (get_cnt != 0 || rsth_cnt != 0 || done_cnt != 0 || busy_mid !== 1'b0) begin
      bad++;
      $display("FAIL enable_off: got gets=%0d rsth=%0d done=%0d busy=%b, want 0 0 0 0",
               get_cnt, rsth_cnt, done_cnt, busy_mid);
    end
  endtask

  task automatic test_threshold_tie();
    int cfg_dark [3] = '{8, 7, 7};
    bit cfg_extra[3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      n_dark     = cfg_dark[k];
      extra_dark = cfg_extra[k];
      run_frame(2, 1'b1, -1, 10'd512);
      total++;
      if (get_cnt != NCELL || done_cnt != 1 || rsth_cnt != 1) begin
        bad++;
        $display("FAIL tie_frame%0d: got gets=%0d done=%0d rsth=%0d, want %0d 1 1",
                 k, get_cnt, done_cnt, rsth_cnt, NCELL);
      end
    end
  endtask

  task automatic test_abort();
    run_frame(0, 1'b1, 100, 10'd512);
    total++;
    if (get_cnt != 101 || done_cnt != 0 || rsth_cnt != 1 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL abort: got gets=%0d done=%0d rsth=%0d busy=%b, want 101 0 1 0",
               get_cnt, done_cnt, rsth_cnt, Busy);
    end
  endtask

  task automatic test_checker();
    run_frame(3, 1'b1, -1, 10'd512);
    total++;
    if (get_cnt != NCELL || done_cnt != 1 || done_cyc != last_get_cyc + 1) begin
      bad++;
      $display("FAIL checker_counts: got gets=%0d done=%0d at %0d, want %0d 1 at %0d",
               get_cnt, done_cnt, done_cyc, NCELL, last_get_cyc + 1);
    end
  endtask

  task automatic test_gray();
    run_frame(4, 1'b1, -1, 10'd201);
    total++;
    if (get_cnt != NCELL) begin
      bad++;
      $display("FAIL gray_201: got gets=%0d, want %0d", get_cnt, NCELL);
    end
    run_frame(4, 1'b1, -1, 10'd200);
    total++;
    if (get_cnt != NCELL || done_cnt != 1) begin
      bad++;
      $display("FAIL gray_200: got gets=%0d done=%0d, want %0d 1", get_cnt, done_cnt, NCELL);
    end
  endtask

  initial begin
    n_dark     = 0;
    extra_dark = 1'b0;
    abort_idx  = -1;
    busy_mid   = 1'b0;
    test_reset();
    test_dark();
    test_bright();
    test_enable_off();
    test_threshold_tie();
    test_abort();
    test_checker();
    test_gray();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
